id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
Instruction-decode stage of the 4-stage MIPS pipeline, directly downstream of the fetch stage. It holds the 32-entry register file and decodes R-type instructions. It registers operands and control into the ID/EX pipeline register. A per-register pending-write scoreboard detects RAW and WAW hazards and drives the stall that freezes fetch; this replaces fetch-side hazard comparison.

Parameters:
SIZE, 32, data/instruction width in bits
REGS, 32, register-file depth; index width is $clog2(REGS)

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
if_valid  input  1  fetch presents a real instruction this cycle
if_instr  input  SIZE  instruction word from fetch
if_pc_4  input  SIZE  PC+4 of if_instr
wb_en  input  1  writeback write enable
wb_reg  input  $clog2(REGS)  writeback destination register
wb_data  input  SIZE  writeback data
stall  output  1  combinational; fetch must hold PC and instruction while high
id_valid  output  1  ID/EX register holds a real instruction (0 = bubble)
id_pc_4  output  SIZE  registered if_pc_4
id_rs_data  output  SIZE  registered rs operand
id_rt_data  output  SIZE  registered rt operand
id_rd  output  $clog2(REGS)  registered destination, instr[15:11]
id_shamt  output  5  registered instr[10:6]
id_funct  output  6  registered instr[5:0]
illegal_op  output  1  sticky; set when a valid instruction has opcode != 0

Behaviour:
- Reset (rst=1 at posedge): all register-file entries, pending[REGS-1:0], id_* outputs, id_valid and illegal_op go to 0. rst overrides every other event in that cycle. An in-flight instruction is discarded. A wb_en in the same cycle is ignored.
- Field extraction: op=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0].
- Register file:
  - Write at posedge when wb_en=1 and wb_reg!=0.
  - r0 always reads 0 and writes to it are dropped.
  - Read is combinational with write-through bypass: if wb_en && wb_reg==rs && rs!=0, the rs read returns wb_data. The same rule applies to rt.
- Hazard term hz(r) = pending[r] && !(wb_en && wb_reg==r) && r!=0.
- stall = if_valid && op==0 && (hz(rs) || hz(rt) || hz(rd)). The hz(rd) term gives the WAW check, so a single pending bit per register is sufficient.
- Issue = if_valid && !stall && op==0. On issue at posedge:
  - ID/EX captures operands, rd, shamt, funct and pc_4.
  - id_valid=1.
  - If rd!=0, set pending[rd].
- No issue:
  - id_valid=0 (bubble).
  - Other id_* outputs hold their previous values.
- op!=0 with if_valid=1: never issues and does not stall. id_valid=0 and illegal_op is set to 1, cleared only by rst.
- Scoreboard clear: wb_en=1 clears pending[wb_reg]. If the same cycle both clears and sets the same register, the set wins.
- Latency: one cycle from issue to id_valid. stall responds in the same cycle as a newly presented if_instr. stall drops in the cycle wb_en targets the blocking register, and the instruction issues at that edge with bypassed data.
- Downstream is always ready; there is no back-pressure input.
- Arithmetic: none. Widths pass through unchanged.

Test Plan:
- Reset: preload r5=25 via wb, assert rst one cycle -> all id_* =0, id_valid=0, pending=0, subsequent read of r5 returns 0.
- Bypass: wb_en=1, wb_reg=5, wb_data=25 in the same cycle as ADD r20,r5,r0 (rs=5) issues -> next cycle id_rs_data=25, id_rt_data=0, id_valid=1, stall=0.
- RAW stall:
  - Setup: issue AND r7,r0,r0 (rd=7), then present OR with rs=7.
  - Required: stall=1 and id_valid=0 every cycle until wb_en/wb_reg=7/wb_data=0x1234.
  - That cycle: stall=0. Next cycle: id_rs_data=0x1234, id_valid=1.
- WAW:
  - Setup: issue SUB with rd=12, then ADD with rd=12 and sources r0.
  - Required: stall=1 until wb_reg=12. pending[12] is then set again by the second issue, checked by a third instruction reading r12 stalling.
- r0 rules: wb_en, wb_reg=0, wb_data=0xFFFF_FFFF, then read r0 -> 0. An instruction with rd=0 issues without setting pending and never causes a stall.
- Illegal opcode: if_valid=1, if_instr=0x8C00_0000 -> stall=0, id_valid=0 next cycle, illegal_op=1 and it stays 1 until rst.

Source files
------------

// File: rtl/id_stage.sv
// id_stage: instruction-decode stage of the 4-stage MIPS pipeline.
// Holds the register file, decodes R-type instructions, and tracks in-flight
// writes with one pending bit per register. Fetch is frozen while an
// instruction would read or overwrite a register that is still pending.
module id_stage #(
  parameter int SIZE = 32,
  parameter int REGS = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_valid,
  input  logic [SIZE-1:0]         if_instr,
  input  logic [SIZE-1:0]         if_pc_4,
  input  logic                    wb_en,
  input  logic [$clog2(REGS)-1:0] wb_reg,
  input  logic [SIZE-1:0]         wb_data,
  output logic                    stall,
  output logic                    id_valid,
  output logic [SIZE-1:0]         id_pc_4,
  output logic [SIZE-1:0]         id_rs_data,
  output logic [SIZE-1:0]         id_rt_data,
  output logic [$clog2(REGS)-1:0] id_rd,
  output logic [4:0]              id_shamt,
  output logic [5:0]              id_funct,
  output logic                    illegal_op
);

  localparam int RW = $clog2(REGS);

  // Register file and the pending-write scoreboard.
  logic [SIZE-1:0] rf [REGS];
  logic [REGS-1:0] pending;
  logic [REGS-1:0] pending_next;

  // Decoded fields of the instruction currently presented by fetch.
  logic [5:0]    op;
  logic [RW-1:0] rs;
  logic [RW-1:0] rt;
  logic [RW-1:0] rd;
  logic [4:0]    shamt;
  logic [5:0]    funct;

  assign op    = if_instr[31:26];
  assign rs    = if_instr[21 +: RW];
  assign rt    = if_instr[16 +: RW];
  assign rd    = if_instr[11 +: RW];
  assign shamt = if_instr[10:6];
  assign funct = if_instr[5:0];

  // Operand values after r0 forcing and write-through bypass.
  logic [SIZE-1:0] rs_data;
  logic [SIZE-1:0] rt_data;

  // Control decisions for this cycle.
  logic r_type;
  logic issue;
  logic hz_rs;
  logic hz_rt;
  logic hz_rd;

  // A register is a hazard when a write to it is still outstanding and that
  // write is not landing this very cycle; r0 can never be a hazard.
  function automatic logic hazard(input logic [RW-1:0] r,
                                  input logic [REGS-1:0] pend,
                                  input logic we,
                                  input logic [RW-1:0] wr);
    hazard = pend[r] && !(we && (wr == r)) && (r != '0);
  endfunction

  // Combinational register read: r0 is hard zero, a same-cycle writeback wins.
  always_comb begin
    rs_data = rf[rs];
    rt_data = rf[rt];
    if (rs == '0) begin
      rs_data = '0;
    end else if (wb_en && (wb_reg == rs)) begin
      rs_data = wb_data;
    end
    if (rt == '0) begin
      rt_data = '0;
    end else if (wb_en && (wb_reg == rt)) begin
      rt_data = wb_data;
    end
  end

  // Hazard detection and issue decision; the rd term covers write-after-write.
  always_comb begin
    r_type = if_valid && (op == 6'd0);
    hz_rs  = hazard(rs, pending, wb_en, wb_reg);
    hz_rt  = hazard(rt, pending, wb_en, wb_reg);
    hz_rd  = hazard(rd, pending, wb_en, wb_reg);
    stall  = r_type && (hz_rs || hz_rt || hz_rd);
    issue  = r_type && !stall;
  end

  // Scoreboard update: a writeback clears its bit, a new issue sets its rd;
  // the set is applied last so it wins when both hit the same register.
  always_comb begin
    pending_next = pending;
    if (wb_en) begin
      pending_next[wb_reg] = 1'b0;
    end
    if (issue && (rd != '0)) begin
      pending_next[rd] = 1'b1;
    end
  end

  // Register-file write port; r0 writes are dropped, reset clears every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REGS; i++) begin
        rf[i] <= '0;
      end
    end else if (wb_en && (wb_reg != '0)) begin
      rf[wb_reg] <= wb_data;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  // ID/EX pipeline register: capture on issue, otherwise insert a bubble and
  // keep the payload fields unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid   <= 1'b0;
      id_pc_4    <= '0;
      id_rs_data <= '0;
      id_rt_data <= '0;
      id_rd      <= '0;
      id_shamt   <= '0;
      id_funct   <= '0;
    end else begin
      id_valid <= issue;
      if (issue) begin
        id_pc_4    <= if_pc_4;
        id_rs_data <= rs_data;
        id_rt_data <= rt_data;
        id_rd      <= rd;
        id_shamt   <= shamt;
        id_funct   <= funct;
      end
    end
  end

  // Sticky flag for any valid instruction that is not R-type.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_op <= 1'b0;
    end else if (if_valid && (op != 6'd0)) begin
      illegal_op <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: directed scenarios followed by random traffic, all
// checked against a behavioural model of registers, pending writes and ID/EX.
module tb_id_stage;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc_4;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_pc_4;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [4:0]  id_rd;
  logic [4:0]  id_shamt;
  logic [5:0]  id_funct;
  logic        illegal_op;

  int checks;
  int errors;

  // Behavioural model state.
  logic [31:0] m_rf [32];
  bit          m_busy [32];
  logic        m_valid;
  logic [31:0] m_pc_4;
  logic [31:0] m_rs_data;
  logic [31:0] m_rt_data;
  logic [4:0]  m_rd;
  logic [4:0]  m_shamt;
  logic [5:0]  m_funct;
  logic        m_illegal;
  logic        last_stall;

  id_stage #(.SIZE(32), .REGS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc_4    (if_pc_4),
    .wb_en      (wb_en),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data),
    .stall      (stall),
    .id_valid   (id_valid),
    .id_pc_4    (id_pc_4),
    .id_rs_data (id_rs_data),
    .id_rt_data (id_rt_data),
    .id_rd      (id_rd),
    .id_shamt   (id_shamt),
    .id_funct   (id_funct),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input int shamt, input int funct);
    logic [4:0] a = rs[4:0];
    logic [4:0] b = rt[4:0];
    logic [4:0] c = rd[4:0];
    logic [4:0] s = shamt[4:0];
    logic [5:0] f = funct[5:0];
    rtype = {6'd0, a, b, c, s, f};
  endfunction

  // Value an instruction would see for register r in the current cycle.
  function automatic logic [31:0] modelRead(input int r);
    if (r == 0) return 32'd0;
    if (wb_en && (int'(wb_reg) == r)) return wb_data;
    return m_rf[r];
  endfunction

  // A register blocks issue while its write is outstanding and not retiring now.
  function automatic bit modelBlocks(input int r);
    return (r != 0) && m_busy[r] && !(wb_en && (int'(wb_reg) == r));
  endfunction

  function automatic bit modelStall();
    int rs = int'(if_instr[25:21]);
    int rt = int'(if_instr[20:16]);
    int rd = int'(if_instr[15:11]);
    if (!if_valid || (if_instr[31:26] != 6'd0)) return 1'b0;
    return modelBlocks(rs) || modelBlocks(rt) || modelBlocks(rd);
  endfunction

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic modelStep(input bit exp_stall);
    int  rs = int'(if_instr[25:21]);
    int  rt = int'(if_instr[20:16]);
    int  rd = int'(if_instr[15:11]);
    bit  goes = if_valid && (if_instr[31:26] == 6'd0) && !exp_stall;
    logic [31:0] a = modelRead(rs);
    logic [31:0] b = modelRead(rt);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_rf[i] = 32'd0;
        m_busy[i] = 1'b0;
      end
      m_valid = 0; m_pc_4 = 0; m_rs_data = 0; m_rt_data = 0;
      m_rd = 0; m_shamt = 0; m_funct = 0; m_illegal = 0;
      return;
    end
    m_valid = goes;
    if (goes) begin
      m_pc_4    = if_pc_4;
      m_rs_data = a;
      m_rt_data = b;
      m_rd      = if_instr[15:11];
      m_shamt   = if_instr[10:6];
      m_funct   = if_instr[5:0];
    end
    if (if_valid && (if_instr[31:26] != 6'd0)) m_illegal = 1'b1;
    if (wb_en) begin
      if (wb_reg != 5'd0) m_rf[wb_reg] = wb_data;
      m_busy[wb_reg] = 1'b0;
    end
    if (goes && (rd != 0)) m_busy[rd] = 1'b1;
  endtask

  // Drives one cycle of inputs, checks stall before the edge and the
  // registered outputs after it.
  task automatic applyStimulus(input bit r, input bit v, input logic [31:0] instr,
                               input logic [31:0] pc4, input bit we,
                               input logic [4:0] wr, input logic [31:0] wd);
    bit exp_stall;
    @(negedge clk);
    rst = r; if_valid = v; if_instr = instr; if_pc_4 = pc4;
    wb_en = we; wb_reg = wr; wb_data = wd;
    #1;
    exp_stall = modelStall();
    last_stall = exp_stall;
    checkOutput("stall", {31'd0, stall}, {31'd0, exp_stall});
    modelStep(exp_stall);
    @(posedge clk);
    #1;
    checkOutput("id_valid",   {31'd0, id_valid},   {31'd0, m_valid});
    checkOutput("id_pc_4",    id_pc_4,             m_pc_4);
    checkOutput("id_rs_data", id_rs_data,          m_rs_data);
    checkOutput("id_rt_data", id_rt_data,          m_rt_data);
    checkOutput("id_rd",      {27'd0, id_rd},      {27'd0, m_rd});
    checkOutput("id_shamt",   {27'd0, id_shamt},   {27'd0, m_shamt});
    checkOutput("id_funct",   {26'd0, id_funct},   {26'd0, m_funct});
    checkOutput("illegal_op", {31'd0, illegal_op}, {31'd0, m_illegal});
  endtask

  initial begin
    logic [31:0] cur;
    checks = 0;
    errors = 0;
    last_stall = 0;
    rst = 1; if_valid = 0; if_instr = 0; if_pc_4 = 0;
    wb_en = 0; wb_reg = 0; wb_data = 0;
    for (int i = 0; i < 32; i++) begin
      m_rf[i] = 32'd0;
      m_busy[i] = 1'b0;
    end
    m_valid = 0; m_pc_4 = 0; m_rs_data = 0; m_rt_data = 0;
    m_rd = 0; m_shamt = 0; m_funct = 0; m_illegal = 0;

    // Reset, preload r5, reset again (with a competing writeback), read r5.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 5, 32'd25);
    applyStimulus(1, 1, rtype(5, 5, 9, 1, 32), 32'h40, 1, 5, 32'd77);
    applyStimulus(0, 1, rtype(5, 0, 0, 0, 32), 32'h44, 0, 0, 0);

    // Bypass: writeback of r5 lands in the same cycle the ADD reads it.
    applyStimulus(0, 1, rtype(5, 0, 20, 0, 32), 32'h48, 1, 5, 32'd25);

    // RAW: AND r7 issues, OR reading r7 stalls until r7 is written back.
    applyStimulus(0, 1, rtype(0, 0, 7, 0, 36), 32'h4c, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1, rtype(7, 0, 8, 0, 37), 32'h50, 0, 0, 0);
    applyStimulus(0, 1, rtype(7, 0, 8, 0, 37), 32'h50, 1, 7, 32'h1234);

    // WAW: SUB r12 then ADD r12 stalls until r12 retires; a reader then stalls.
    applyStimulus(0, 1, rtype(0, 0, 12, 0, 34), 32'h54, 0, 0, 0);
    for (int i = 0; i < 2; i++)
      applyStimulus(0, 1, rtype(0, 0, 12, 0, 32), 32'h58, 0, 0, 0);
    applyStimulus(0, 1, rtype(0, 0, 12, 0, 32), 32'h58, 1, 12, 32'hABCD);
    applyStimulus(0, 1, rtype(12, 0, 13, 0, 32), 32'h5c, 0, 0, 0);
    applyStimulus(0, 1, rtype(12, 0, 13, 0, 32), 32'h5c, 1, 12, 32'h5555);

    // r0 rules: writes are dropped, rd=0 never sets a pending bit.
    applyStimulus(0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF);
    applyStimulus(0, 1, rtype(0, 0, 0, 3, 32), 32'h60, 0, 0, 0);
    applyStimulus(0, 1, rtype(0, 0, 0, 4, 33), 32'h64, 0, 0, 0);

    // Illegal opcode: no stall, bubble, sticky flag.
    applyStimulus(0, 1, 32'h8C00_0000, 32'h68, 0, 0, 0);
    applyStimulus(0, 1, rtype(0, 0, 0, 0, 32), 32'h6c, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Random traffic over a small register window so hazards occur often;
    // a stalled instruction is held just as fetch would.
    cur = rtype(1, 2, 3, 0, 32);
    for (int n = 0; n < 400; n++) begin
      bit r = ($urandom_range(0, 63) == 0);
      bit v = ($urandom_range(0, 3) != 0);
      if (!last_stall) begin
        cur = rtype($urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 31),
                    $urandom_range(0, 63));
        if ($urandom_range(0, 15) == 0) cur[31:26] = 6'($urandom_range(1, 63));
      end else begin
        v = 1;
      end
      applyStimulus(r, v, cur, $urandom, $urandom_range(0, 1),
                    5'($urandom_range(0, 7)), $urandom);
    end

    // Final reset clears the sticky flag and the pipeline register.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
